// File: rtl/param_data_memory_if.sv
// -----------------------------------------------------------------------------
// param_data_memory_if
//
// Purpose: request/response bundle between the MEM stage and the data memory.
//
// Parameters:
//   DATA_W  word width in bits
//   ADDR_W  address width in bits
//
// Signals:
//   MEMREAD     read request, sampled on the rising edge
//   MEMWRITE    write request, sampled on the rising edge
//   ADDRESS     word address
//   WRITE_DATA  write data
//   READ_DATA   registered read data, holds between reads
//   READ_VALID  one-cycle pulse, READ_DATA was updated by a read
//   BUSY        init sweep in progress, requests are ignored
//   ADDR_ERR    one-cycle pulse, last accepted request was out of range
//
// Modports: master (datapath side), slave (memory side).
// -----------------------------------------------------------------------------
interface param_data_memory_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic              MEMREAD;
  logic              MEMWRITE;
  logic [ADDR_W-1:0] ADDRESS;
  logic [DATA_W-1:0] WRITE_DATA;
  logic [DATA_W-1:0] READ_DATA;
  logic              READ_VALID;
  logic              BUSY;
  logic              ADDR_ERR;

  modport master (
    output MEMREAD, MEMWRITE, ADDRESS, WRITE_DATA,
    input  READ_DATA, READ_VALID, BUSY, ADDR_ERR
  );

  modport slave (
    input  MEMREAD, MEMWRITE, ADDRESS, WRITE_DATA,
    output READ_DATA, READ_VALID, BUSY, ADDR_ERR
  );
endinterface

// File: rtl/param_data_memory.sv
// -----------------------------------------------------------------------------
// param_data_memory
//
// Purpose: parametrised single-port data memory for the MEM stage. After every
// reset a hardware sweep writes a fixed signed test pattern, one word per
// cycle, while BUSY is high:
//   pattern(i) = i                    for i <  DEPTH/2
//              = -(i - DEPTH/2)       for i >= DEPTH/2   (modulo 2^DATA_W)
// In RUN it serves reads (1-cycle latency, READ_VALID strobe) and writes, and
// flags out-of-range addresses with ADDR_ERR.
//
// Parameters:
//   DATA_W  word width (default 8)
//   ADDR_W  address port width (default 8)
//   DEPTH   number of words (default 32); even and <= 2^ADDR_W
//
// Ports:
//   CLK  clock, all state updates on the rising edge
//   RST  synchronous active-high reset
//   bus  param_data_memory_if.slave request/response bundle
//
// Build option:
//   DMEM_RDW_BYPASS_EN  when defined, a read and write to the same in-range
//                       address on one edge returns the new write data;
//                       otherwise the pre-write word is returned.
// -----------------------------------------------------------------------------
module param_data_memory #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 32
) (
  input logic                CLK,
  input logic                RST,
  param_data_memory_if.slave bus
);

  localparam int              CNT_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned     HALF    = DEPTH / 2;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] LAST   = CNT_W'(DEPTH - 1);

  typedef enum logic {INIT, RUN} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              in_range;
  logic [CNT_W-1:0]  idx;
  logic [DATA_W-1:0] rd_word;

  logic [DATA_W-1:0] mem [DEPTH];

  function automatic logic [DATA_W-1:0] pattern(input logic [CNT_W-1:0] i);
    int unsigned iu;
    iu = 32'(i);
    if (iu < HALF) return DATA_W'(iu);
    return ~DATA_W'(iu - HALF) + DATA_W'(1);
  endfunction

  // Extra leading zero keeps the compare correct when DEPTH == 2^ADDR_W.
  assign in_range = ({1'b0, bus.ADDRESS} < DEPTH_L);
  assign idx      = bus.ADDRESS[CNT_W-1:0];

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    rd_word = mem[idx];
`ifdef DMEM_RDW_BYPASS_EN
    // Write-first: forward the incoming data when a write hits the same word.
    if (bus.MEMWRITE) rd_word = bus.WRITE_DATA;
`endif
  end

  // NOTE: the storage array has no reset branch; reset leaves contents alone
  // and the init sweep rewrites them, which keeps it mappable to RAM.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      if (state == INIT) begin
        mem[cnt] <= pattern(cnt);
      end else if (bus.MEMWRITE && in_range) begin
        mem[idx] <= bus.WRITE_DATA;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state          <= INIT;
      cnt            <= '0;
      bus.READ_DATA  <= '0;
      bus.READ_VALID <= 1'b0;
      bus.ADDR_ERR   <= 1'b0;
      bus.BUSY       <= 1'b1;
    end else begin
      case (state)
        INIT: begin
          cnt            <= cnt + CNT_W'(1);
          bus.READ_VALID <= 1'b0;
          bus.ADDR_ERR   <= 1'b0;
          if (cnt == LAST) begin
            state    <= RUN;
            bus.BUSY <= 1'b0;
          end
        end
        RUN: begin
          bus.READ_VALID <= bus.MEMREAD;
          bus.ADDR_ERR   <= (bus.MEMREAD || bus.MEMWRITE) && !in_range;
          if (bus.MEMREAD) begin
            bus.READ_DATA <= in_range ? rd_word : '0;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_param_data_memory.sv
module tb_param_data_memory;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 32;

`ifdef DMEM_RDW_BYPASS_EN
  localparam logic [7:0] RDW_EXP = 8'h3C;
`else
  localparam logic [7:0] RDW_EXP = 8'h07;
`endif

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  param_data_memory_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  param_data_memory #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       valid;
    logic       err;
    logic       busy;
  } obs_t;

  typedef struct packed {
    logic       rd;
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    obs_t       exp;
  } stim_t;

  obs_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic obs_t sample();
    obs_t o;
    o.data  = bus.READ_DATA;
    o.valid = bus.READ_VALID;
    o.err   = bus.ADDR_ERR;
    o.busy  = bus.BUSY;
    return o;
  endfunction

  // Stimulus entry for RUN traffic; BUSY is expected low.
  function automatic stim_t s(input logic rd, input logic wr, input logic [7:0] a,
                              input logic [7:0] d, input logic [7:0] ed,
                              input logic ev, input logic ee);
    stim_t r;
    r.rd = rd; r.wr = wr; r.addr = a; r.wdata = d;
    r.exp.data = ed; r.exp.valid = ev; r.exp.err = ee; r.exp.busy = 1'b0;
    return r;
  endfunction

  task automatic drive(input logic rd, input logic wr, input logic [7:0] a, input logic [7:0] d);
    bus.MEMREAD    = rd;
    bus.MEMWRITE   = wr;
    bus.ADDRESS    = a;
    bus.WRITE_DATA = d;
    @(posedge CLK);
    #1;
  endtask

  task automatic apply_reset(input int edges);
    RST = 1'b1;
    repeat (edges) drive(1'b0, 1'b0, 8'h00, 8'h00);
    RST = 1'b0;
  endtask

  // Idle edges with RST low until BUSY falls; bounded.
  task automatic sweep_count(output int n);
    obs_t o;
    n = 0;
    do begin
      drive(1'b0, 1'b0, 8'h00, 8'h00);
      n++;
      o = sample();
    end while (o.busy && n < 100);
  endtask

  task automatic test_reset();
    obs_t got;
    obs_t e;
    int   n;
    apply_reset(2);
    got = sample();
    e   = '{data: 8'h00, valid: 1'b0, err: 1'b0, busy: 1'b1};
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL reset_state got data=%02h valid=%b err=%b busy=%b expected data=%02h valid=%b err=%b busy=%b",
               got.data, got.valid, got.err, got.busy, e.data, e.valid, e.err, e.busy);
    end
    sweep_count(n);
    checks++;
    if (n !== DEPTH) begin
      errors++;
      $display("FAIL init_busy_edges got %0d expected %0d", n, DEPTH);
    end
  endtask

  task automatic test_init_pattern();
    stim_t v[$];
    obs_t  got;
    obs_t  e;
    v = '{s(1, 0, 8'd5,  8'h00, 8'h05, 1, 0),
          s(1, 0, 8'd16, 8'h00, 8'h00, 1, 0),
          s(1, 0, 8'd17, 8'h00, 8'hFF, 1, 0),
          s(1, 0, 8'd31, 8'h00, 8'hF1, 1, 0),
          s(0, 0, 8'd0,  8'h00, 8'hF1, 0, 0)};
    foreach (v[i]) begin
      sb.push_back(v[i].exp);
      drive(v[i].rd, v[i].wr, v[i].addr, v[i].wdata);
      got = sample();
      e   = sb.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL init_pattern[%0d] got data=%02h valid=%b err=%b busy=%b expected data=%02h valid=%b err=%b busy=%b",
                 i, got.data, got.valid, got.err, got.busy, e.data, e.valid, e.err, e.busy);
      end
    end
  endtask

  task automatic test_write_read();
    stim_t v[$];
    obs_t  got;
    obs_t  e;
    v = '{s(0, 1, 8'd3, 8'hA5, 8'hF1, 0, 0),
          s(1, 0, 8'd3, 8'h00, 8'hA5, 1, 0),
          s(0, 0, 8'd3, 8'h00, 8'hA5, 0, 0),
          s(0, 0, 8'd9, 8'h00, 8'hA5, 0, 0),
          s(1, 0, 8'd0, 8'h00, 8'h00, 1, 0),
          s(1, 0, 8'd3, 8'h00, 8'hA5, 1, 0)};
    foreach (v[i]) begin
      sb.push_back(v[i].exp);
      drive(v[i].rd, v[i].wr, v[i].addr, v[i].wdata);
      got = sample();
      e   = sb.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL write_read[%0d] got data=%02h valid=%b err=%b busy=%b expected data=%02h valid=%b err=%b busy=%b",
                 i, got.data, got.valid, got.err, got.busy, e.data, e.valid, e.err, e.busy);
      end
    end
  endtask

  task automatic test_read_during_write();
    stim_t v[$];
    obs_t  got;
    obs_t  e;
    v = '{s(1, 0, 8'd7, 8'h00, 8'h07,   1, 0),
          s(1, 1, 8'd7, 8'h3C, RDW_EXP, 1, 0),
          s(1, 0, 8'd7, 8'h00, 8'h3C,   1, 0),
          s(0, 0, 8'd7, 8'h00, 8'h3C,   0, 0)};
    foreach (v[i]) begin
      sb.push_back(v[i].exp);
      drive(v[i].rd, v[i].wr, v[i].addr, v[i].wdata);
      got = sample();
      e   = sb.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL rdw[%0d] got data=%02h valid=%b err=%b busy=%b expected data=%02h valid=%b err=%b busy=%b",
                 i, got.data, got.valid, got.err, got.busy, e.data, e.valid, e.err, e.busy);
      end
    end
  endtask

  task automatic test_out_of_range();
    stim_t v[$];
    obs_t  got;
    obs_t  e;
    v = '{s(0, 1, 8'd40,  8'h55, 8'h3C, 0, 1),
          s(1, 0, 8'd40,  8'h00, 8'h00, 1, 1),
          s(0, 0, 8'd40,  8'h00, 8'h00, 0, 0),
          s(1, 0, 8'd8,   8'h00, 8'h08, 1, 0),
          s(1, 0, 8'd32,  8'h00, 8'h00, 1, 1),
          s(1, 0, 8'd31,  8'h00, 8'hF1, 1, 0),
          s(0, 1, 8'd255, 8'h77, 8'hF1, 0, 1),
          s(1, 0, 8'd31,  8'h00, 8'hF1, 1, 0)};
    foreach (v[i]) begin
      sb.push_back(v[i].exp);
      drive(v[i].rd, v[i].wr, v[i].addr, v[i].wdata);
      got = sample();
      e   = sb.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL out_of_range[%0d] got data=%02h valid=%b err=%b busy=%b expected data=%02h valid=%b err=%b busy=%b",
                 i, got.data, got.valid, got.err, got.busy, e.data, e.valid, e.err, e.busy);
      end
    end
  endtask

  task automatic test_busy_requests();
    obs_t got;
    obs_t e;
    int   n;
    apply_reset(2);
    n = 0;
    do begin
      // Alternate an in-range read+write with an out-of-range one.
      drive(1'b1, 1'b1, (n % 2 == 1) ? 8'd40 : 8'd2, 8'h99);
      n++;
      got = sample();
      checks++;
      if (got.valid !== 1'b0 || got.err !== 1'b0 || got.data !== 8'h00) begin
        errors++;
        $display("FAIL busy_ignore[%0d] got data=%02h valid=%b err=%b expected data=00 valid=0 err=0",
                 n, got.data, got.valid, got.err);
      end
    end while (got.busy && n < 100);
    checks++;
    if (n !== DEPTH) begin
      errors++;
      $display("FAIL busy_edges got %0d expected %0d", n, DEPTH);
    end
    sb.push_back('{data: 8'h02, valid: 1'b1, err: 1'b0, busy: 1'b0});
    drive(1'b1, 1'b0, 8'd2, 8'h00);
    got = sample();
    e   = sb.pop_front();
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL busy_read2 got data=%02h valid=%b err=%b busy=%b expected data=%02h valid=%b err=%b busy=%b",
               got.data, got.valid, got.err, got.busy, e.data, e.valid, e.err, e.busy);
    end
  endtask

  task automatic test_reset_mid_sweep();
    stim_t v[$];
    obs_t  got;
    obs_t  e;
    int    n;
    v = '{s(0, 1, 8'd0, 8'hEE, 8'h02, 0, 0),
          s(1, 0, 8'd0, 8'h00, 8'hEE, 1, 0)};
    foreach (v[i]) begin
      sb.push_back(v[i].exp);
      drive(v[i].rd, v[i].wr, v[i].addr, v[i].wdata);
      got = sample();
      e   = sb.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL pre_reset[%0d] got data=%02h valid=%b err=%b busy=%b expected data=%02h valid=%b err=%b busy=%b",
                 i, got.data, got.valid, got.err, got.busy, e.data, e.valid, e.err, e.busy);
      end
    end
    apply_reset(1);
    repeat (10) drive(1'b0, 1'b0, 8'h00, 8'h00);
    apply_reset(2);
    sweep_count(n);
    checks++;
    if (n !== DEPTH) begin
      errors++;
      $display("FAIL restart_busy_edges got %0d expected %0d", n, DEPTH);
    end
    v = '{s(1, 0, 8'd0,  8'h00, 8'h00, 1, 0),
          s(1, 0, 8'd20, 8'h00, 8'hFC, 1, 0),
          s(1, 0, 8'd3,  8'h00, 8'h03, 1, 0)};
    foreach (v[i]) begin
      sb.push_back(v[i].exp);
      drive(v[i].rd, v[i].wr, v[i].addr, v[i].wdata);
      got = sample();
      e   = sb.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL post_reset[%0d] got data=%02h valid=%b err=%b busy=%b expected data=%02h valid=%b err=%b busy=%b",
                 i, got.data, got.valid, got.err, got.busy, e.data, e.valid, e.err, e.busy);
      end
    end
  endtask

  initial begin
    bus.MEMREAD    = 1'b0;
    bus.MEMWRITE   = 1'b0;
    bus.ADDRESS    = '0;
    bus.WRITE_DATA = '0;
    test_reset();
    test_init_pattern();
    test_write_read();
    test_read_during_write();
    test_out_of_range();
    test_busy_requests();
    test_reset_mid_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
